// File: rtl/psum_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : psum_ctrl_pkg
// Description : Shared types and saturation limits for the PE partial-sum
//               accumulation controller.
// Revision    : 1.0 - initial release
// ============================================================================
package psum_ctrl_pkg;

  localparam int DATA_W = 20;

  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/psum_sat_add.sv
`default_nettype none
// ============================================================================
// Module      : psum_sat_add
// Description : Combinational signed saturating adder, DATA_W + DATA_W -> DATA_W.
// Revision    : 1.0 - initial release
// ============================================================================
module psum_sat_add #(
  parameter int DATA_W = psum_ctrl_pkg::DATA_W
) (
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [DATA_W-1:0] o_sum
);

  localparam logic signed [DATA_W-1:0] c_SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] c_SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W:0] w_wide;

  assign w_wide = {i_a[DATA_W-1], i_a} + {i_b[DATA_W-1], i_b};

  // The two top bits of the extended sum disagree exactly on overflow.
  always_comb begin
    o_sum = w_wide[DATA_W-1:0];
    if (w_wide[DATA_W] != w_wide[DATA_W-1]) begin
      o_sum = w_wide[DATA_W] ? c_SAT_MIN : c_SAT_MAX;
    end
  end

endmodule
`default_nettype wire

// File: rtl/psum_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : psum_accum_ctrl
// Description : Groups PE partial sums into saturated results and streams
//               them out over valid/ready, pulsing done at job end.
// Revision    : 1.0 - initial release
// ============================================================================
module psum_accum_ctrl #(
  parameter int DATA_W = psum_ctrl_pkg::DATA_W,
  parameter int STEP_W = 8,
  parameter int OUT_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [STEP_W-1:0] cfg_steps,
  input  logic [OUT_W-1:0]  cfg_outs,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] PE_sum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  import psum_ctrl_pkg::*;

  localparam logic [STEP_W-1:0] c_STEP_ONE = STEP_W'(1);
  localparam logic [OUT_W-1:0]  c_OUT_ONE  = OUT_W'(1);

  state_t                    r_state;
  logic signed [DATA_W-1:0]  r_acc;
  logic [STEP_W-1:0]         r_step_cnt;
  logic [OUT_W-1:0]          r_out_cnt;
  logic [STEP_W-1:0]         r_steps;
  logic [OUT_W-1:0]          r_outs;
  logic [DATA_W-1:0]         r_out_data;
  logic                      r_out_valid;
  logic                      r_done;

  logic signed [DATA_W-1:0]  w_acc_in;
  logic signed [DATA_W-1:0]  w_sum;
  logic                      w_last_step;
  logic                      w_last_out;

  // First sample of a group adds to zero, so one adder covers both cases.
  assign w_acc_in    = (r_step_cnt == '0) ? '0 : r_acc;
  assign w_last_step = (r_step_cnt == (r_steps - c_STEP_ONE));
  assign w_last_out  = (r_out_cnt == (r_outs - c_OUT_ONE));

  psum_sat_add #(
    .DATA_W (DATA_W)
  ) u_sat_add (
    .i_a   (w_acc_in),
    .i_b   ($signed(PE_sum)),
    .o_sum (w_sum)
  );

  assign in_ready  = (r_state == ACCUM);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign done      = r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_step_cnt  <= '0;
      r_out_cnt   <= '0;
      r_steps     <= '0;
      r_outs      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        // Abort in IDLE also swallows a coincident start.
        if (r_state != IDLE) begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_acc       <= '0;
          r_step_cnt  <= '0;
          r_out_cnt   <= '0;
        end
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_steps    <= (cfg_steps == '0) ? c_STEP_ONE : cfg_steps;
              r_outs     <= cfg_outs;
              r_step_cnt <= '0;
              r_out_cnt  <= '0;
              if (cfg_outs == '0) begin
                r_done <= 1'b1;
              end else begin
                r_state <= ACCUM;
              end
            end
          end
          ACCUM: begin
            if (in_valid) begin
              r_acc <= w_sum;
              if (w_last_step) begin
                r_out_data  <= w_sum;
                r_out_valid <= 1'b1;
                r_step_cnt  <= '0;
                r_state     <= HOLD;
              end else begin
                r_step_cnt <= r_step_cnt + c_STEP_ONE;
              end
            end
          end
          HOLD: begin
            if (out_ready) begin
              r_out_valid <= 1'b0;
              r_out_cnt   <= r_out_cnt + c_OUT_ONE;
              if (w_last_out) begin
                r_done  <= 1'b1;
                r_state <= IDLE;
              end else begin
                r_state <= ACCUM;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_psum_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_psum_accum_ctrl
// Description : Vector table, directed corner sequences and randomized jobs
//               checked against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psum_accum_ctrl;

  localparam int DW   = 20;
  localparam int SW   = 8;
  localparam int OW   = 10;
  localparam int MAXV = 524287;
  localparam int MINV = -524288;

  typedef int iq_t[$];

  typedef struct {
    int steps;
    int outs;
    int ns;
    int samp[8];
    int nr;
    int expr[4];
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [SW-1:0] cfg_steps;
  logic [OW-1:0] cfg_outs;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] PE_sum;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  psum_accum_ctrl #(
    .DATA_W (DW),
    .STEP_W (SW),
    .OUT_W  (OW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .cfg_steps (cfg_steps),
    .cfg_outs  (cfg_outs),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .PE_sum    (PE_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int sx(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int clamp(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return int'(v);
  endfunction

  // Reference: each result is a left fold of its group with a clamp per add.
  function automatic iq_t model(input int steps, input int outs, input iq_t s);
    iq_t e;
    int  eff;
    int  acc;
    eff = (steps == 0) ? 1 : steps;
    for (int g = 0; g < outs; g++) begin
      acc = s[g*eff];
      for (int k = 1; k < eff; k++) acc = clamp(longint'(acc) + longint'(s[g*eff+k]));
      e.push_back(acc);
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int steps, input int outs);
    cfg_steps = SW'(steps);
    cfg_outs  = OW'(outs);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic run_job(input int steps, input int outs, input iq_t s, input iq_t e,
                         input int val_pct, input int rdy_pct, input string tag);
    int eff;
    int si;
    int ri;
    int grp;
    int cyc;
    int spurious;
    bit fin;
    bit acc_now;
    bit hs;
    eff = (steps == 0) ? 1 : steps;
    si = 0; ri = 0; grp = 0; cyc = 0; spurious = 0; fin = 1'b0;
    start_job(steps, outs);
    check({tag, "_busy_start"}, int'(busy), 1);
    while (!fin && cyc < 4000) begin
      in_valid  = (si < s.size()) && ($urandom_range(99) < val_pct);
      PE_sum    = (si < s.size()) ? DW'(s[si]) : DW'($urandom);
      out_ready = ($urandom_range(99) < rdy_pct);
      acc_now   = in_valid && in_ready;
      hs        = out_valid && out_ready;
      if (hs) begin
        check($sformatf("%s_data%0d", tag, ri), sx(out_data), (ri < e.size()) ? e[ri] : 0);
        ri++;
      end
      tick();
      cyc++;
      if (acc_now) begin
        si++;
        grp++;
        if (grp == eff) begin
          grp = 0;
          check({tag, "_latency"}, int'(out_valid), 1);
        end
      end
      if (hs && ri == outs) begin
        check({tag, "_done"}, int'(done), 1);
        check({tag, "_valid_drop"}, int'(out_valid), 0);
        fin = 1'b1;
      end else if (done) begin
        spurious++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({tag, "_finished"}, int'(fin), 1);
    check({tag, "_spurious_done"}, spurious, 0);
    tick();
    check({tag, "_busy_end"}, int'(busy), 0);
    check({tag, "_done_1cyc"}, int'(done), 0);
  endtask

  vec_t tbl[5];

  initial begin
    iq_t s;
    iq_t e;
    int  st;
    int  no;
    int  eff;
    int  r;

    tbl[0].steps = 4; tbl[0].outs = 2; tbl[0].ns = 8; tbl[0].nr = 2;
    tbl[0].samp = '{1, 2, 3, 4, 5, 6, 7, 8};
    tbl[0].expr = '{10, 26, 0, 0};
    tbl[1].steps = 2; tbl[1].outs = 1; tbl[1].ns = 2; tbl[1].nr = 1;
    tbl[1].samp = '{100, -30, 0, 0, 0, 0, 0, 0};
    tbl[1].expr = '{70, 0, 0, 0};
    tbl[2].steps = 3; tbl[2].outs = 1; tbl[2].ns = 3; tbl[2].nr = 1;
    tbl[2].samp = '{300000, 300000, -5, 0, 0, 0, 0, 0};
    tbl[2].expr = '{524282, 0, 0, 0};
    tbl[3].steps = 0; tbl[3].outs = 2; tbl[3].ns = 2; tbl[3].nr = 2;
    tbl[3].samp = '{-524288, -7, 0, 0, 0, 0, 0, 0};
    tbl[3].expr = '{-524288, -7, 0, 0};
    tbl[4].steps = 2; tbl[4].outs = 2; tbl[4].ns = 4; tbl[4].nr = 2;
    tbl[4].samp = '{524287, 1, -524288, -1, 0, 0, 0, 0};
    tbl[4].expr = '{524287, -524288, 0, 0};

    reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cfg_steps = '0; cfg_outs = '0; PE_sum = '0;
    tick();
    tick();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_out_data", sx(out_data), 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      s = {};
      e = {};
      for (int k = 0; k < tbl[i].ns; k++) s.push_back(tbl[i].samp[k]);
      for (int k = 0; k < tbl[i].nr; k++) e.push_back(tbl[i].expr[k]);
      run_job(tbl[i].steps, tbl[i].outs, s, e, 100, 100, $sformatf("vec%0d", i));
    end

    // Backpressure: result must hold steady while the consumer stalls.
    start_job(2, 1);
    in_valid = 1'b1; PE_sum = DW'(100); tick();
    PE_sum = DW'(-30); tick();
    in_valid = 1'b1; PE_sum = DW'(55);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", int'(out_valid), 1);
      check("bp_data", sx(out_data), 70);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_done", int'(done), 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1; tick();
    out_ready = 1'b0;
    check("bp_done_pulse", int'(done), 1);
    tick();
    check("bp_busy_end", int'(busy), 0);

    // Abort after two samples of a four-step group.
    start_job(4, 1);
    in_valid = 1'b1; PE_sum = DW'(11); tick();
    PE_sum = DW'(12); tick();
    in_valid = 1'b0;
    check("ab_busy_before", int'(busy), 1);
    abort = 1'b1; tick();
    abort = 1'b0;
    check("ab_busy", int'(busy), 0);
    check("ab_in_ready", int'(in_ready), 0);
    check("ab_out_valid", int'(out_valid), 0);
    check("ab_done", int'(done), 0);
    tick();
    check("ab_done_later", int'(done), 0);
    run_job(4, 1, '{1, 1, 1, 1}, '{4}, 100, 100, "ab_restart");

    // Start pulse while accumulating must not disturb the job.
    start_job(3, 1);
    in_valid = 1'b1; PE_sum = DW'(5); tick();
    in_valid = 1'b0; cfg_steps = SW'(1); cfg_outs = OW'(0); start = 1'b1; tick();
    start = 1'b0;
    check("sa_busy", int'(busy), 1);
    check("sa_done", int'(done), 0);
    in_valid = 1'b1; PE_sum = DW'(6); tick();
    check("sa_valid_early", int'(out_valid), 0);
    PE_sum = DW'(7); tick();
    in_valid = 1'b0;
    check("sa_valid", int'(out_valid), 1);
    check("sa_data", sx(out_data), 18);
    out_ready = 1'b1; tick();
    out_ready = 1'b0;
    check("sa_done_pulse", int'(done), 1);
    tick();

    // Zero-output job completes immediately without leaving IDLE.
    start_job(3, 0);
    check("z_done", int'(done), 1);
    check("z_busy", int'(busy), 0);
    tick();
    check("z_done_clear", int'(done), 0);
    check("z_busy_after", int'(busy), 0);

    // Coincident start and abort in IDLE.
    cfg_steps = SW'(2); cfg_outs = OW'(2); start = 1'b1; abort = 1'b1; tick();
    start = 1'b0; abort = 1'b0;
    check("sab_busy", int'(busy), 0);
    check("sab_done", int'(done), 0);
    tick();

    // Asynchronous reset between clock edges with a result pending.
    start_job(1, 2);
    in_valid = 1'b1; PE_sum = DW'(123); tick();
    in_valid = 1'b0;
    check("ar_valid_pre", int'(out_valid), 1);
    check("ar_data_pre", sx(out_data), 123);
    #2 reset = 1'b1;
    #1;
    check("ar_out_valid", int'(out_valid), 0);
    check("ar_out_data", sx(out_data), 0);
    check("ar_busy", int'(busy), 0);
    check("ar_in_ready", int'(in_ready), 0);
    check("ar_done", int'(done), 0);
    #3 reset = 1'b0;
    tick();
    run_job(4, 2, '{1, 2, 3, 4, 5, 6, 7, 8}, '{10, 26}, 100, 100, "ar_restart");

    // Randomized jobs with random stalls and backpressure.
    for (int j = 0; j < 20; j++) begin
      st  = int'($urandom_range(0, 5));
      no  = int'($urandom_range(1, 4));
      eff = (st == 0) ? 1 : st;
      s = {};
      for (int k = 0; k < eff * no; k++) begin
        r = int'($urandom_range(0, 3));
        if (r == 0)      s.push_back(MAXV - int'($urandom_range(0, 1000)));
        else if (r == 1) s.push_back(MINV + int'($urandom_range(0, 1000)));
        else             s.push_back(int'($urandom_range(0, 1048575)) - 524288);
      end
      e = model(st, no, s);
      run_job(st, no, s, e, 70, 60, $sformatf("rnd%0d", j));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
